// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B - BI, one bit per clock LSB first.
// Define SERSUB_OVF_EN to add the registered signed-overflow output o_v.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_bi,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_d,
   output logic             o_bo,
   output logic             o_z
`ifdef SERSUB_OVF_EN
   ,
   output logic             o_v
`endif
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_d;
   logic             r_br;
   logic [CW-1:0]    r_cnt;
   logic             r_last;
`ifdef SERSUB_OVF_EN
   logic             r_a_msb;
   logic             r_b_msb;
`endif

   logic w_a_bit;
   logic w_b_bit;
   logic w_d_bit;
   logic w_br_next;

   // Single full-subtractor cell fed by the LSBs of the operand shifters.
   assign w_a_bit   = r_a[0];
   assign w_b_bit   = r_b[0];
   assign w_d_bit   = w_a_bit ^ w_b_bit ^ r_br;
   assign w_br_next = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_br);

   assign o_busy = (r_state == S_RUN);
   assign o_done = (r_state == S_FIN);

   // NOTE: all state updates use non-blocking assignments so every register
   // samples the pre-edge values, exactly like the flops they describe.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_d     <= '0;
         r_br    <= 1'b0;
         r_cnt   <= '0;
         r_last  <= 1'b0;
         o_d     <= '0;
         o_bo    <= 1'b0;
         o_z     <= 1'b0;
`ifdef SERSUB_OVF_EN
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         o_v     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_RUN: begin
               if (!r_last) begin
                  r_a  <= r_a >> 1;
                  r_b  <= r_b >> 1;
                  r_d  <= {w_d_bit, r_d[WIDTH-1:1]};
                  r_br <= w_br_next;
                  if (r_cnt == CW'(WIDTH - 1)) begin
                     r_last <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end else begin
                  // All bits are in: publish the result on the way into FIN.
                  o_d     <= r_d;
                  o_bo    <= r_br;
                  o_z     <= (r_d == '0);
`ifdef SERSUB_OVF_EN
                  o_v     <= (r_a_msb != r_b_msb) && (r_d[WIDTH-1] != r_a_msb);
`endif
                  r_state <= S_FIN;
               end
            end
            default: begin
               // IDLE and FIN both accept a new operation.
               if (i_start) begin
                  r_a     <= i_a;
                  r_b     <= i_b;
                  r_br    <= i_bi;
                  r_cnt   <= '0;
                  r_last  <= 1'b0;
`ifdef SERSUB_OVF_EN
                  r_a_msb <= i_a[WIDTH-1];
                  r_b_msb <= i_b[WIDTH-1];
`endif
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference.
// Build with SERSUB_OVF_EN defined to also check the overflow output.
module tb_serial_subtractor;

   localparam int WIDTH = 8;
`ifdef SERSUB_OVF_EN
   localparam int RES_W = WIDTH + 3;
`else
   localparam int RES_W = WIDTH + 2;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bi;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] d;
   logic             bo;
   logic             z;
`ifdef SERSUB_OVF_EN
   logic             v;
`endif

   int checks   = 0;
   int failures = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_a     (a),
      .i_b     (b),
      .i_bi    (bi),
      .o_busy  (busy),
      .o_done  (done),
      .o_d     (d),
      .o_bo    (bo),
      .o_z     (z)
`ifdef SERSUB_OVF_EN
      ,
      .o_v     (v)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer subtraction; borrow = negative true result,
   // overflow = signed true result outside the WIDTH-bit signed range.
   function automatic logic [RES_W-1:0] ref_result(input logic [WIDTH-1:0] ra,
                                                   input logic [WIDTH-1:0] rb,
                                                   input logic rbi);
      int diff;
      logic [WIDTH-1:0] rd;
`ifdef SERSUB_OVF_EN
      int sdiff;
      logic rv;
`endif
      diff = int'(ra) - int'(rb) - int'(rbi);
      rd   = WIDTH'(diff);
`ifdef SERSUB_OVF_EN
      sdiff = int'($signed(ra)) - int'($signed(rb)) - int'(rbi);
      rv    = (sdiff > 127) || (sdiff < -128);
      return {rd, diff < 0, rd == '0, rv};
`else
      return {rd, diff < 0, rd == '0};
`endif
   endfunction

   function automatic logic [RES_W-1:0] obs_result();
`ifdef SERSUB_OVF_EN
      return {d, bo, z, v};
`else
      return {d, bo, z};
`endif
   endfunction

   // Launch one operation, optionally pulse a stray START at cycle junk_at of
   // RUN, and wait (bounded) for DONE. lat = -1 on timeout.
   task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                         input logic obi, input int junk_at,
                         output int lat, output int busy_n, output logic held);
      logic [WIDTH-1:0] d_entry;
      a = oa; b = ob; bi = obi; start = 1'b1;
      tick();
      start = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom); bi = 1'($urandom);
      d_entry = d;
      lat = -1; busy_n = 0; held = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (done) begin
            lat = c;
            break;
         end
         if (busy) busy_n++;
         if (d !== d_entry) held = 1'b0;
         start = (c == junk_at);
         if (start) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); bi = 1'($urandom);
         end
         tick();
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
      tick(); tick();
      checks++;
      if ({busy, done, obs_result()} !== '0) begin
         failures++;
         $display("FAIL reset_state: got busy=%b done=%b res=%h, want all zero",
                  busy, done, obs_result());
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      logic [2*WIDTH:0] vec [5];
      int lat, busy_n;
      logic held;
      logic [RES_W-1:0] exp_r;
      vec = '{{8'h05, 8'h03, 1'b0}, {8'h03, 8'h05, 1'b0}, {8'h10, 8'h0F, 1'b1},
              {8'h80, 8'h01, 1'b0}, {8'h7F, 8'hFF, 1'b0}};
      foreach (vec[i]) begin
         exp_r = ref_result(vec[i][2*WIDTH:WIDTH+1], vec[i][WIDTH:1], vec[i][0]);
         run_op(vec[i][2*WIDTH:WIDTH+1], vec[i][WIDTH:1], vec[i][0], -1, lat, busy_n, held);
         checks++;
         if (lat != WIDTH + 1 || busy_n != WIDTH + 1 || !held) begin
            failures++;
            $display("FAIL directed_timing[%0d]: got lat=%0d busy=%0d held=%b, want %0d %0d 1",
                     i, lat, busy_n, held, WIDTH + 1, WIDTH + 1);
         end
         checks++;
         if (obs_result() !== exp_r) begin
            failures++;
            $display("FAIL directed_result[%0d]: got %h, want %h", i, obs_result(), exp_r);
         end
         tick();
         checks++;
         if (done !== 1'b0 || obs_result() !== exp_r) begin
            failures++;
            $display("FAIL directed_strobe_hold[%0d]: got done=%b res=%h, want 0 %h",
                     i, done, obs_result(), exp_r);
         end
      end
   endtask

   task automatic test_random();
      int lat, busy_n;
      logic held;
      logic [WIDTH-1:0] ra, rb;
      logic rbi;
      logic [RES_W-1:0] exp_r;
      for (int n = 0; n < 24; n++) begin
         ra = WIDTH'($urandom); rb = WIDTH'($urandom); rbi = 1'($urandom);
         exp_r = ref_result(ra, rb, rbi);
         run_op(ra, rb, rbi, -1, lat, busy_n, held);
         checks++;
         if (lat != WIDTH + 1 || obs_result() !== exp_r) begin
            failures++;
            $display("FAIL random[%0d] a=%h b=%h bi=%b: got lat=%0d res=%h, want lat=%0d res=%h",
                     n, ra, rb, rbi, lat, obs_result(), WIDTH + 1, exp_r);
         end
         if ($urandom_range(1, 0) == 1) tick();
      end
   endtask

   task automatic test_start_ignored();
      int lat, busy_n;
      logic held;
      logic [RES_W-1:0] exp_r;
      exp_r = ref_result(8'h5A, 8'h33, 1'b0);
      run_op(8'h5A, 8'h33, 1'b0, 2, lat, busy_n, held);
      checks++;
      if (lat != WIDTH + 1 || busy_n != WIDTH + 1 || obs_result() !== exp_r) begin
         failures++;
         $display("FAIL start_ignored: got lat=%0d busy=%0d res=%h, want %0d %0d %h",
                  lat, busy_n, obs_result(), WIDTH + 1, WIDTH + 1, exp_r);
      end
   endtask

   task automatic test_back_to_back();
      int lat, busy_n;
      logic held;
      logic [RES_W-1:0] exp_r;
      run_op(8'h40, 8'h22, 1'b0, -1, lat, busy_n, held);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL b2b_first_done: got %b, want 1", done);
      end
      // Now sitting in the FIN cycle: START here must be accepted at once.
      exp_r = ref_result(8'hFF, 8'hFF, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b0, -1, lat, busy_n, held);
      checks++;
      if (lat != WIDTH + 1 || obs_result() !== exp_r || d !== 8'h00 || z !== 1'b1) begin
         failures++;
         $display("FAIL b2b_second: got lat=%0d res=%h, want %0d %h",
                  lat, obs_result(), WIDTH + 1, exp_r);
      end
      tick();
   endtask

   task automatic test_rst_midrun();
      int lat, busy_n, done_seen;
      logic held;
      a = 8'h77; b = 8'h11; bi = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({busy, done, obs_result()} !== '0) begin
         failures++;
         $display("FAIL rst_midrun_state: got busy=%b done=%b res=%h, want all zero",
                  busy, done, obs_result());
      end
      rst = 1'b0;
      done_seen = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (done) done_seen++;
      end
      checks++;
      if (done_seen != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_midrun_no_done: got done_cycles=%0d busy=%b, want 0 0",
                  done_seen, busy);
      end
      run_op(8'h09, 8'h04, 1'b0, -1, lat, busy_n, held);
      checks++;
      if (lat != WIDTH + 1 || d !== 8'h05 || obs_result() !== ref_result(8'h09, 8'h04, 1'b0)) begin
         failures++;
         $display("FAIL rst_midrun_recover: got lat=%0d d=%h, want %0d 05",
                  lat, d, WIDTH + 1);
      end
      tick();
   endtask

   task automatic test_rst_start();
      rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34; bi = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL rst_start_priority: got busy=%b done=%b, want 0 0", busy, done);
      end
      rst = 1'b0; start = 1'b0;
      tick(); tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL rst_start_idle: got busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_back_to_back();
      test_rst_midrun();
      test_rst_start();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
